// File: rtl/dram_arbiter.sv
// Round-robin DRAM responder: serves one core request at a time against a
// single-port synchronous RAM and returns per-core completion strobes.
module dram_arbiter #(
  parameter int WIDTH     = 8,
  parameter int NUM_CORES = 4,
  parameter int RD_LAT    = 1
) (
  input  logic                       Clk,
  input  logic                       Rst_n,
  input  logic [NUM_CORES-1:0]       core_memREAD,
  input  logic [NUM_CORES-1:0]       core_memWRITE,
  input  logic [NUM_CORES*WIDTH-1:0] core_addr,
  input  logic [NUM_CORES*WIDTH-1:0] core_wdata,
  output logic [WIDTH-1:0]           core_rdata,
  output logic [NUM_CORES-1:0]       memAV,
  output logic [WIDTH-1:0]           ram_addr,
  output logic [WIDTH-1:0]           ram_wdata,
  output logic                       ram_we,
  output logic                       ram_re,
  input  logic [WIDTH-1:0]           ram_rdata,
  output logic                       busy,
  output logic [2:0]                 grant_id,
  output logic                       proto_err
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

  state_t           state_q, state_d;
  logic [2:0]       last_q, last_d;
  logic [2:0]       gid_q, gid_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             wr_q, wr_d;
  logic             perr_q, perr_d;
  logic [1:0]       cnt_q, cnt_d;

  // Per-core views padded to 8 entries so a 3-bit index always fits.
  logic [7:0]       req8, rd8, wr8;
  logic [WIDTH-1:0] addr_arr  [8];
  logic [WIDTH-1:0] wdata_arr [8];
  logic [2:0]       win;
  logic             found;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_core
      if (gi < NUM_CORES) begin : g_used
        assign addr_arr[gi]  = core_addr[gi*WIDTH +: WIDTH];
        assign wdata_arr[gi] = core_wdata[gi*WIDTH +: WIDTH];
        assign rd8[gi]       = core_memREAD[gi];
        assign wr8[gi]       = core_memWRITE[gi];
        assign memAV[gi]     = (state_q == DONE) && (gid_q == 3'(gi));
        assign req8[gi]      = (core_memREAD[gi] | core_memWRITE[gi]) & ~memAV[gi];
      end else begin : g_unused
        assign addr_arr[gi]  = '0;
        assign wdata_arr[gi] = '0;
        assign rd8[gi]       = 1'b0;
        assign wr8[gi]       = 1'b0;
        assign req8[gi]      = 1'b0;
      end
    end
  endgenerate

  // Descending scan so the nearest index after last_q is the one that sticks.
  always_comb begin
    win   = last_q;
    found = 1'b0;
    for (int k = NUM_CORES; k >= 1; k--) begin
      if (req8[3'((int'(last_q) + k) % NUM_CORES)]) begin
        win   = 3'((int'(last_q) + k) % NUM_CORES);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gid_d   = gid_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    wr_d    = wr_q;
    perr_d  = perr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          gid_d   = win;
          last_d  = win;
          addr_d  = addr_arr[win];
          wdata_d = wdata_arr[win];
          wr_d    = wr8[win];
          if (rd8[win] && wr8[win]) perr_d = 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (wr_q) begin
          state_d = DONE;
        end else begin
          cnt_d   = 2'(RD_LAT - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 2'd0) begin
          rdata_d = ram_rdata;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      last_q  <= 3'(NUM_CORES - 1);
      gid_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      wr_q    <= 1'b0;
      perr_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gid_q   <= gid_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      wr_q    <= wr_d;
      perr_q  <= perr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Strobes decode straight from state so an async reset drops them at once.
  assign ram_we     = (state_q == ACCESS) && wr_q;
  assign ram_re     = (state_q == ACCESS) && !wr_q;
  assign busy       = (state_q != IDLE);
  assign ram_addr   = addr_q;
  assign ram_wdata  = wdata_q;
  assign core_rdata = rdata_q;
  assign grant_id   = gid_q;
  assign proto_err  = perr_q;

endmodule

// File: tb/tb_dram_arbiter.sv
// Scoreboard bench for dram_arbiter: transaction-level reference model feeds
// expected completions into a queue that a separate monitor checks.
module tb_dram_arbiter;
  localparam int N   = 4;
  localparam int W   = 8;
  localparam int LAT = 3;

  logic           Clk;
  logic           Rst_n;
  logic [N-1:0]   core_memREAD;
  logic [N-1:0]   core_memWRITE;
  logic [N*W-1:0] core_addr;
  logic [N*W-1:0] core_wdata;
  logic [W-1:0]   core_rdata;
  logic [N-1:0]   memAV;
  logic [W-1:0]   ram_addr, ram_wdata, ram_rdata;
  logic           ram_we, ram_re, busy, proto_err;
  logic [2:0]     grant_id;

  dram_arbiter #(.WIDTH(W), .NUM_CORES(N), .RD_LAT(LAT)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .core_memREAD(core_memREAD), .core_memWRITE(core_memWRITE),
    .core_addr(core_addr), .core_wdata(core_wdata),
    .core_rdata(core_rdata), .memAV(memAV),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_we(ram_we), .ram_re(ram_re), .ram_rdata(ram_rdata),
    .busy(busy), .grant_id(grant_id), .proto_err(proto_err)
  );

  typedef struct packed {
    int       core;
    int       done_cyc;
    bit       is_wr;
    bit [7:0] addr;
    bit [7:0] wdata;
    bit [7:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   served[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  bit   exp_proto = 0;

  // driver mailboxes: main writes dir_* / persist_target, driver consumes
  int       dir_seq[N], taken[N], persist_target[N], persist_done[N];
  bit       dir_rd[N], dir_wr[N], hold[N];
  bit [7:0] dir_addr[N], dir_data[N];
  bit       rand_en = 0;

  logic [7:0] sim_mem [256];
  logic [7:0] rd_pipe [LAT];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  initial begin
    Clk = 0;
    forever #5 Clk = ~Clk;
  end

  // DRAM model: synchronous write, read data valid LAT edges after ram_re
  assign ram_rdata = rd_pipe[LAT-1];
  initial begin
    for (int i = 0; i < 256; i++) sim_mem[i] = 8'(i) ^ 8'h5A;
    sim_mem[8'h20] = 8'h3C;
    for (int k = 0; k < LAT; k++) rd_pipe[k] = 8'h00;
    forever begin
      @(posedge Clk);
      if (ram_we) sim_mem[ram_addr] <= ram_wdata;
      for (int k = LAT-1; k > 0; k--) rd_pipe[k] <= rd_pipe[k-1];
      rd_pipe[0] <= ram_re ? sim_mem[ram_addr] : 8'h00;
    end
  end

  // Reference model: serves one request at a time; next winner is the first
  // requester after the previous winner; completion 2 (+LAT for reads)
  // cycles after the deciding idle cycle, next decision the cycle after.
  initial begin
    bit [7:0] ref_mem [256];
    bit [7:0] exp_rdata;
    int       last, next_free, win;
    exp_t     e;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'h5A;
    ref_mem[8'h20] = 8'h3C;
    last = N-1; next_free = 0; exp_rdata = 0;
    forever begin
      @(posedge Clk);
      if (!Rst_n) begin
        sb.delete();
        last = N-1; next_free = 0; exp_rdata = 0; exp_proto = 0;
      end else if (cyc >= next_free) begin
        win = -1;
        for (int k = 1; k <= N; k++)
          if (win < 0 && (core_memREAD[(last+k)%N] || core_memWRITE[(last+k)%N])) win = (last+k) % N;
        if (win >= 0) begin
          e.core  = win;
          e.is_wr = core_memWRITE[win];
          e.addr  = core_addr[win*W +: W];
          e.wdata = core_wdata[win*W +: W];
          if (core_memREAD[win] && core_memWRITE[win]) exp_proto = 1;
          if (e.is_wr) ref_mem[e.addr] = e.wdata;
          else exp_rdata = ref_mem[e.addr];
          e.rdata    = exp_rdata;
          e.done_cyc = cyc + 2 + (e.is_wr ? 0 : LAT);
          next_free  = e.done_cyc + 1;
          last       = win;
          sb.push_back(e);
        end
      end
      cyc++;
    end
  end

  // Monitor: checks RAM-side access and each completion against the queue
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      if (Rst_n) begin
        if (ram_we || ram_re) begin
          if (sb.size() == 0) fail_now("unexpected_ram_access");
          else begin
            e = sb[0];
            chk("ram_we", 32'(ram_we), 32'(e.is_wr));
            chk("ram_re", 32'(ram_re), 32'(!e.is_wr));
            chk("ram_addr", 32'(ram_addr), 32'(e.addr));
            if (e.is_wr) chk("ram_wdata", 32'(ram_wdata), 32'(e.wdata));
            chk("access_cycle", 32'(cyc), 32'(e.done_cyc - 1 - (e.is_wr ? 0 : LAT)));
          end
        end
        if (memAV != '0) begin
          if (sb.size() == 0) fail_now("unexpected_memAV");
          else begin
            e = sb.pop_front();
            chk("memAV", 32'(memAV), 32'(1) << e.core);
            chk("done_cycle", 32'(cyc), 32'(e.done_cyc));
            chk("core_rdata", 32'(core_rdata), 32'(e.rdata));
            chk("grant_id", 32'(grant_id), 32'(e.core));
            served.push_back(e.core);
            $display("[TB] cycle %0d core %0d %s addr %02h data %02h", cyc, e.core,
                     e.is_wr ? "WR" : "RD", e.addr, e.is_wr ? e.wdata : core_rdata);
          end
        end else if (sb.size() > 0 && cyc > sb[0].done_cyc) begin
          fail_now("missing_memAV");
          void'(sb.pop_front());
        end
      end
    end
  end

  // Core driver: holds each request until its memAV, then stays low one cycle
  initial begin
    int r;
    core_memREAD = '0; core_memWRITE = '0; core_addr = '0; core_wdata = '0;
    for (int i = 0; i < N; i++) begin
      taken[i] = 0; hold[i] = 0; persist_done[i] = 0;
    end
    forever begin
      @(negedge Clk);
      for (int i = 0; i < N; i++) begin
        if (core_memREAD[i] || core_memWRITE[i]) begin
          if (memAV[i]) begin
            core_memREAD[i] = 0; core_memWRITE[i] = 0; hold[i] = 1;
          end
        end else if (hold[i]) begin
          hold[i] = 0;
        end else if (dir_seq[i] != taken[i]) begin
          taken[i] = dir_seq[i];
          core_memREAD[i] = dir_rd[i]; core_memWRITE[i] = dir_wr[i];
          core_addr[i*W +: W] = dir_addr[i]; core_wdata[i*W +: W] = dir_data[i];
        end else if (persist_done[i] < persist_target[i] || (rand_en && $urandom_range(0, 5) == 0)) begin
          if (persist_done[i] < persist_target[i]) persist_done[i]++;
          r = $urandom_range(0, 15);
          core_memREAD[i]  = (r == 0) || (r >= 8);
          core_memWRITE[i] = (r < 8);
          if (persist_done[i] <= persist_target[i] && !rand_en) begin
            core_memREAD[i] = (r >= 8); core_memWRITE[i] = (r < 8);
          end
          core_addr[i*W +: W]  = 8'($urandom_range(128, 255));
          core_wdata[i*W +: W] = 8'($urandom);
        end
      end
    end
  end

  task automatic issue(input int i, input bit rd, input bit wr, input bit [7:0] a, input bit [7:0] d);
    dir_rd[i] = rd; dir_wr[i] = wr; dir_addr[i] = a; dir_data[i] = d;
    dir_seq[i]++;
  endtask

  task automatic wait_quiet(input string name);
    int  n;
    bit  quiet;
    n = 0;
    quiet = 0;
    repeat (2) begin @(negedge Clk); #1; end
    while (!quiet && n < 3000) begin
      quiet = (core_memREAD == '0) && (core_memWRITE == '0) && (sb.size() == 0);
      for (int i = 0; i < N; i++)
        if (dir_seq[i] != taken[i] || persist_done[i] != persist_target[i]) quiet = 0;
      if (!quiet) begin @(negedge Clk); #1; n++; end
    end
    if (!quiet) fail_now({name, "_timeout"});
  endtask

  initial begin
    int base, c0, c1, bad;
    for (int i = 0; i < N; i++) begin
      dir_seq[i] = 0; persist_target[i] = 0;
    end
    Rst_n = 0;
    #1;
    // reset state
    chk("rst_busy", 32'(busy), 0);
    chk("rst_memAV", 32'(memAV), 0);
    chk("rst_ram_we", 32'(ram_we), 0);
    chk("rst_ram_re", 32'(ram_re), 0);
    chk("rst_proto_err", 32'(proto_err), 0);
    chk("rst_core_rdata", 32'(core_rdata), 0);
    chk("rst_ram_addr", 32'(ram_addr), 0);
    chk("rst_ram_wdata", 32'(ram_wdata), 0);
    chk("rst_grant_id", 32'(grant_id), 0);

    // all four cores request from reset
    for (int i = 0; i < N; i++) issue(i, 0, 1, 8'(8'h40 + i), 8'($urandom));
    repeat (3) @(negedge Clk);
    Rst_n = 1;
    base = served.size();
    wait_quiet("rr_all");
    for (int k = 0; k < N; k++) chk("rr_order", 32'(served[base+k]), 32'(k));

    // cores 0 and 3 only
    @(negedge Clk); #1;
    issue(0, 1, 0, 8'h40, 0);
    issue(3, 1, 0, 8'h43, 0);
    base = served.size();
    wait_quiet("rr_03");
    chk("rr03_first", 32'(served[base]), 0);
    chk("rr03_second", 32'(served[base+1]), 3);

    // starvation: cores 0 and 1 continuously for 20 grants
    base = served.size();
    persist_target[0] += 10;
    persist_target[1] += 10;
    wait_quiet("starve");
    c0 = 0; c1 = 0; bad = 0;
    for (int k = base; k < served.size(); k++) begin
      if (served[k] == 0) c0++;
      if (served[k] == 1) c1++;
      if (k > base && served[k] == served[k-1]) bad++;
    end
    chk("starve_core0", 32'(c0), 10);
    chk("starve_core1", 32'(c1), 10);
    chk("starve_repeats", 32'(bad), 0);

    // single write core 2
    base = served.size();
    issue(2, 0, 1, 8'h10, 8'hA5);
    wait_quiet("wr_single");
    chk("wr_core", 32'(served[base]), 2);
    chk("wr_mem", 32'(sim_mem[8'h10]), 32'hA5);

    // single read core 1 of preloaded location; write must not disturb core_rdata
    issue(1, 1, 0, 8'h20, 0);
    wait_quiet("rd_single");
    chk("rd_value", 32'(core_rdata), 32'h3C);
    issue(2, 0, 1, 8'h21, 8'h11);
    wait_quiet("rd_hold");
    chk("rd_value_held", 32'(core_rdata), 32'h3C);

    // protocol error: read+write together performs the write
    chk("proto_before", 32'(proto_err), 0);
    issue(3, 1, 1, 8'h30, 8'h77);
    wait_quiet("proto");
    chk("proto_set", 32'(proto_err), 1);
    chk("proto_write_done", 32'(sim_mem[8'h30]), 32'h77);
    issue(3, 1, 0, 8'h30, 0);
    wait_quiet("proto_clean");
    chk("proto_sticky", 32'(proto_err), 1);

    // randomized traffic
    rand_en = 1;
    repeat (600) @(negedge Clk);
    #1;
    rand_en = 0;
    wait_quiet("random");
    chk("proto_random", 32'(proto_err), 32'(exp_proto));

    // reset during WAIT of a core-1 read
    issue(1, 1, 0, 8'h20, 0);
    begin
      int n = 0;
      while (!ram_re && n < 50) begin @(negedge Clk); #1; n++; end
      if (!ram_re) fail_now("mid_rst_no_ram_re");
    end
    @(posedge Clk); #2;
    Rst_n = 0;
    #1;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_ram_re", 32'(ram_re), 0);
    chk("mid_rst_ram_we", 32'(ram_we), 0);
    chk("mid_rst_memAV", 32'(memAV), 0);
    chk("mid_rst_proto", 32'(proto_err), 0);
    issue(0, 1, 0, 8'h21, 0);
    repeat (3) begin
      @(negedge Clk); #1;
      chk("mid_rst_memAV_hold", 32'(memAV), 0);
    end
    base = served.size();
    Rst_n = 1;
    wait_quiet("after_rst");
    chk("after_rst_first", 32'(served[base]), 0);
    chk("after_rst_second", 32'(served[base+1]), 1);
    chk("after_rst_count", 32'(served.size() - base), 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/dram_arbiter.md
Name: dram_arbiter

Overview:
Shared data-memory responder for the multi-core array. It accepts memREAD/memWRITE requests from NUM_CORES cores and arbitrates among them round-robin. It drives a single-port synchronous DRAM and returns per-core memAV completion strobes with read data. It is the memory-side end of the core's DRAM_addr / DRAM_dataOut / DRAM_dataIn / memAV interface.

Parameters:
WIDTH, 8, data and address width, matches core WIDTH
NUM_CORES, 4, number of requesting cores (2..8)
RD_LAT, 1, DRAM read latency in cycles from the ram_re cycle to valid ram_rdata (1..4)

Ports:
Clk  input  1  system clock, rising edge
Rst_n  input  1  asynchronous active-low reset
core_memREAD  input  NUM_CORES  per-core read request, bit i = core i
core_memWRITE  input  NUM_CORES  per-core write request
core_addr  input  NUM_CORES*WIDTH  flattened DRAM_addr, core i at [i*WIDTH +: WIDTH]
core_wdata  input  NUM_CORES*WIDTH  flattened DRAM_dataOut
core_rdata  output  WIDTH  read data broadcast to all cores (DRAM_dataIn)
memAV  output  NUM_CORES  one-cycle completion strobe per core
ram_addr  output  WIDTH  DRAM address
ram_wdata  output  WIDTH  DRAM write data
ram_we  output  1  DRAM write enable
ram_re  output  1  DRAM read enable
ram_rdata  input  WIDTH  DRAM read data
busy  output  1  high in every state except IDLE
grant_id  output  3  index of the core currently being served
proto_err  output  1  sticky protocol-error flag

Behaviour:
- Reset (async, Rst_n=0): state=IDLE; memAV, ram_we, ram_re, busy, proto_err = 0; core_rdata, ram_addr, ram_wdata, grant_id = 0; last_grant = NUM_CORES-1, so core 0 wins first. Assertion mid-access aborts it immediately; ram_we/ram_re fall without waiting for a clock edge; no memAV is issued for the aborted request.
- Request contract: a core holds its request, addr and wdata stable until it sees memAV[i]=1, then drops the request by the next edge. A core whose memAV bit is high in the current cycle is masked from arbitration.
- FSM:
  IDLE: req[i] = core_memREAD[i] | core_memWRITE[i]. If any req is high, grant the first requesting index searching last_grant+1, last_grant+2, ... modulo NUM_CORES. On that edge latch addr, wdata and op; update grant_id and last_grant; go to ACCESS.
  ACCESS (1 cycle): ram_addr/ram_wdata driven from latches. On write, ram_we=1 and next state is DONE. On read, ram_re=1 and next state is WAIT.
  WAIT (RD_LAT cycles, internal down-counter): on the edge ending the last WAIT cycle, capture ram_rdata into core_rdata; go to DONE.
  DONE (1 cycle): memAV[grant_id]=1, all other memAV bits 0; go to IDLE.
- Latency from the granting IDLE edge to the memAV cycle: write = 2 cycles; read = 2+RD_LAT cycles. The minimum gap between two back-to-back grants is one IDLE cycle.
- core_rdata holds the last read value until the next read capture; writes do not change it.
- ram_addr/ram_wdata hold their latched values outside ACCESS. ram_we and ram_re are never high together, and are high only in ACCESS.
- Read and write both high from the same core at grant: perform the write, and set proto_err=1 (sticky until reset).
- Requests arriving while busy wait; there is no queueing beyond the held request lines.
- Fairness: with all cores requesting continuously, each core is served exactly once per NUM_CORES grants.
- Address arithmetic: none; addresses pass through unmodified. grant_id is zero-extended to 3 bits.

Test Plan:
- Single write: core 2 writes addr 0x10, data 0xA5 -> ram_we=1 for one cycle with ram_addr=0x10, ram_wdata=0xA5; memAV=4'b0100 exactly 2 cycles after grant; other memAV bits stay 0.
- Single read, RD_LAT=1 and RD_LAT=3: preload DRAM[0x20]=0x3C, core 1 reads 0x20 -> core_rdata=0x3C and memAV=4'b0010 at 3 and 5 cycles after grant respectively; core_rdata stays 0x3C afterwards.
- Round-robin: all 4 cores request from reset and each drops its request after its memAV -> grant order 0,1,2,3. Re-request from cores 0 and 3 only -> core 0 wins, then core 3.
- Starvation check: cores 0 and 1 request continuously for 20 grants -> grants alternate 0,1,0,1,...; each core receives exactly 10.
- Protocol error: core 3 raises memREAD and memWRITE together -> write is performed, proto_err=1 and stays 1 after subsequent clean transactions until Rst_n low.
- Reset mid-read: drop Rst_n during WAIT -> ram_re=0 and busy=0 asynchronously; no memAV pulse. After release, a pending core-0 request is granted first.
